// File: rtl/fifo_traffic_gen.sv
// fifo_traffic_gen: active FIFO exerciser. Each pass fills the FIFO with an
// incrementing sequence and drains it. Read data is checked against the same
// sequence, and the full/empty/overrun/underrun flags are probed. The error
// count, the first mismatching expected value and a pass/fail verdict are
// reported when the run ends.
module fifo_traffic_gen #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned NUM_PASSES = 4,
    parameter bit          PROBE_EN   = 1'b1,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              wr_enb,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_enb,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic              fifo_overrun,
    input  logic              fifo_underrun,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       error_count,
    output logic [DATA_W-1:0] first_err_exp
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FILL,
        S_FULL_CHK,
        S_OVF_PROBE,
        S_OVF_CHK,
        S_DRAIN,
        S_EMPTY_CHK,
        S_UDF_PROBE,
        S_UDF_CHK,
        S_DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] wr_seq;
    logic [DATA_W-1:0] rd_seq;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  rd_cnt;
    logic [7:0]        pass_cnt;
    logic [TMR_W-1:0]  stall;
    logic              cmp_pend;
    logic              have_first;

    logic              wr_acc;
    logic              rd_acc;
    logic              mismatch;
    logic              chk_fail;
    logic              stall_cond;
    logic              stall_hit;
    logic [TMR_W-1:0]  stall_next;
    logic              pass_end;
    logic              to_done;
    logic [1:0]        err_inc;
    logic [16:0]       err_sum;
    logic [15:0]       err_next;

    // FIFO request generation: flow-controlled in FILL/DRAIN, forced in the probe states
    always_comb begin
        wr_enb  = 1'b0;
        rd_enb  = 1'b0;
        wr_data = wr_seq;
        case (state)
            S_FILL:      wr_enb = !fifo_full && (wr_cnt < CNT_W'(DEPTH));
            S_OVF_PROBE: begin
                wr_enb  = 1'b1;
                wr_data = '1;
            end
            S_DRAIN:     rd_enb = !fifo_empty && (rd_cnt < CNT_W'(DEPTH));
            S_UDF_PROBE: rd_enb = 1'b1;
            default:     ;
        endcase
    end

    // Error sources for this cycle and the saturated next error count
    always_comb begin
        wr_acc     = (state == S_FILL) && wr_enb;
        rd_acc     = (state == S_DRAIN) && rd_enb;
        mismatch   = cmp_pend && (rd_data != rd_seq);
        chk_fail   = ((state == S_FULL_CHK)  && !fifo_full)    ||
                     ((state == S_OVF_CHK)   && !fifo_overrun) ||
                     ((state == S_EMPTY_CHK) && !fifo_empty)   ||
                     ((state == S_UDF_CHK)   && !fifo_underrun);
        stall_cond = ((state == S_FILL) && !wr_acc) || ((state == S_DRAIN) && !rd_acc);
        stall_next = stall + 1'b1;
        stall_hit  = stall_cond && (stall_next == TMR_W'(TIMEOUT));
        pass_end   = (state == S_UDF_CHK) || ((state == S_EMPTY_CHK) && !PROBE_EN);
        to_done    = stall_hit || (pass_end && (pass_cnt == 8'(NUM_PASSES - 1)));
        err_inc    = {1'b0, mismatch} + {1'b0, chk_fail} + {1'b0, stall_hit};
        err_sum    = {1'b0, error_count} + 17'(err_inc);
        err_next   = err_sum[16] ? '1 : err_sum[15:0];
    end

    // Sequencer: pass/phase state, sequence counters, stall timer and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            wr_seq        <= '0;
            rd_seq        <= '0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            pass_cnt      <= '0;
            stall         <= '0;
            cmp_pend      <= 1'b0;
            have_first    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            error_count   <= '0;
            first_err_exp <= '0;
        end else begin
            error_count <= err_next;
            if (mismatch && !have_first) begin
                first_err_exp <= rd_seq;
                have_first    <= 1'b1;
            end
            // A read accepted this cycle is compared against rd_seq on the next one
            cmp_pend <= rd_acc;
            if (cmp_pend) begin
                rd_seq <= rd_seq + 1'b1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        error_count   <= '0;
                        first_err_exp <= '0;
                        have_first    <= 1'b0;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        busy          <= 1'b1;
                        pass_cnt      <= '0;
                        wr_cnt        <= '0;
                        rd_cnt        <= '0;
                        stall         <= '0;
                        state         <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (wr_acc) begin
                        wr_seq <= wr_seq + 1'b1;
                        wr_cnt <= wr_cnt + 1'b1;
                        stall  <= '0;
                        if (wr_cnt == CNT_W'(DEPTH - 1)) begin
                            state <= S_FULL_CHK;
                        end
                    end else begin
                        stall <= stall_next;
                    end
                end
                S_FULL_CHK:  state <= PROBE_EN ? S_OVF_PROBE : S_DRAIN;
                S_OVF_PROBE: state <= S_OVF_CHK;
                S_OVF_CHK:   state <= S_DRAIN;
                S_DRAIN: begin
                    if (rd_acc) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        stall  <= '0;
                        if (rd_cnt == CNT_W'(DEPTH - 1)) begin
                            state <= S_EMPTY_CHK;
                        end
                    end else begin
                        stall <= stall_next;
                    end
                end
                S_EMPTY_CHK: begin
                    if (PROBE_EN) begin
                        state <= S_UDF_PROBE;
                    end
                end
                S_UDF_PROBE: state <= S_UDF_CHK;
                default:     ;
            endcase

            // End of pass and run termination override the per-state transitions above
            if (pass_end) begin
                pass_cnt <= pass_cnt + 1'b1;
                wr_cnt   <= '0;
                rd_cnt   <= '0;
                stall    <= '0;
                state    <= S_FILL;
            end
            if (to_done) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_next == 16'd0);
            end
        end
    end

endmodule

// File: tb/tb_fifo_traffic_gen.sv
// Directed bench for fifo_traffic_gen: two generators (4 and 20 passes), each
// driving its own behavioural 16-deep FIFO whose flags can be forced or
// whose read data can be corrupted for fault scenarios.
module tb_fifo_traffic_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0]       start = '0;
    logic [1:0]       wr_enb, rd_enb, full_in, empty_in, ovf_in, udf_in;
    logic [1:0]       busy, done, pass;
    logic [1:0][7:0]  wr_data, rd_data, first_err_exp;
    logic [1:0][15:0] error_count;

    logic        force_full0 = 1'b0;
    logic        force_full1 = 1'b0;
    logic        no_ovf      = 1'b0;
    int unsigned corrupt_idx = 32'hFFFF_FFFF;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    fifo_traffic_gen #(.DATA_W(8), .DEPTH(16), .NUM_PASSES(4), .PROBE_EN(1'b1), .TIMEOUT(1024)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .wr_enb(wr_enb[0]), .wr_data(wr_data[0]), .rd_enb(rd_enb[0]), .rd_data(rd_data[0]),
        .fifo_full(full_in[0]), .fifo_empty(empty_in[0]), .fifo_overrun(ovf_in[0]), .fifo_underrun(udf_in[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .error_count(error_count[0]), .first_err_exp(first_err_exp[0])
    );

    fifo_traffic_gen #(.DATA_W(8), .DEPTH(16), .NUM_PASSES(20), .PROBE_EN(1'b1), .TIMEOUT(1024)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .wr_enb(wr_enb[1]), .wr_data(wr_data[1]), .rd_enb(rd_enb[1]), .rd_data(rd_data[1]),
        .fifo_full(full_in[1]), .fifo_empty(empty_in[1]), .fifo_overrun(ovf_in[1]), .fifo_underrun(udf_in[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .error_count(error_count[1]), .first_err_exp(first_err_exp[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [7:0]  mem [16];
        logic [4:0]  cnt;
        logic [3:0]  wp, rp;
        logic [7:0]  rdq;
        logic        ovf, udf, m_full, m_empty, w_ok, r_ok;
        int unsigned nrd;
        int unsigned n_wr, n_bad, n_wff, n_ree, n_both;
        logic [7:0]  wexp, first_wr;

        assign m_full  = (cnt == 5'd16);
        assign m_empty = (cnt == 5'd0);
        assign w_ok    = wr_enb[g] && !m_full;
        assign r_ok    = rd_enb[g] && !m_empty;

        assign full_in[g]  = (g == 0) ? ((m_full && !force_full0) || force_full1) : m_full;
        assign empty_in[g] = m_empty;
        assign ovf_in[g]   = (g == 0) ? (ovf && !no_ovf) : ovf;
        assign udf_in[g]   = udf;
        assign rd_data[g]  = rdq;

        // Behavioural FIFO with registered read data and one-cycle error flags
        always @(posedge clk) begin
            if (rst) begin
                cnt <= '0; wp <= '0; rp <= '0; rdq <= '0; ovf <= 1'b0; udf <= 1'b0; nrd <= 0;
            end else begin
                ovf <= wr_enb[g] && m_full;
                udf <= rd_enb[g] && m_empty;
                if (w_ok) begin
                    mem[wp] <= wr_data[g];
                    wp      <= wp + 4'd1;
                end
                if (r_ok) begin
                    rdq <= ((g == 0) && (nrd == corrupt_idx)) ? (mem[rp] ^ 8'h01) : mem[rp];
                    rp  <= rp + 4'd1;
                    nrd <= nrd + 1;
                end
                cnt <= cnt + 5'(w_ok) - 5'(r_ok);
            end
        end

        // Pin monitor: write sequence, writes seen while full, reads seen while empty, overlap
        always @(posedge clk) begin
            if (rst) begin
                n_wr <= 0; n_bad <= 0; n_wff <= 0; n_ree <= 0; n_both <= 0; wexp <= '0; first_wr <= 8'hAA;
            end else begin
                if (wr_enb[g] && !full_in[g]) begin
                    if (wr_data[g] !== wexp) n_bad <= n_bad + 1;
                    if (n_wr == 0) first_wr <= wr_data[g];
                    wexp <= wexp + 8'd1;
                    n_wr <= n_wr + 1;
                end
                if (wr_enb[g] && full_in[g])  n_wff  <= n_wff + 1;
                if (rd_enb[g] && empty_in[g]) n_ree  <= n_ree + 1;
                if (wr_enb[g] && rd_enb[g])   n_both <= n_both + 1;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        start = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start(input int g);
        start[g] = 1'b1;
        @(posedge clk);
        #1 start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int unsigned budget, output int unsigned n);
        n = 0;
        while (done[g] !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if ({wr_enb[0], rd_enb[0], busy[0], done[0], pass[0]} !== 5'b0) begin miscompares++; $display("FAIL reset_ctl: got %b expected 00000", {wr_enb[0], rd_enb[0], busy[0], done[0], pass[0]}); end
        vectors++; if (error_count[0] !== 16'd0) begin miscompares++; $display("FAIL reset_err: got %0h expected 0", error_count[0]); end
        vectors++; if ({wr_data[0], first_err_exp[0]} !== 16'd0) begin miscompares++; $display("FAIL reset_data: got %h expected 0000", {wr_data[0], first_err_exp[0]}); end
        #1 rst = 1'b0;
    endtask

    task automatic test_good_run();
        int unsigned n;
        do_reset();
        pulse_start(0);
        vectors++; if (busy[0] !== 1'b1) begin miscompares++; $display("FAIL good_busy: got %b expected 1", busy[0]); end
        wait_done(0, 2000, n);
        vectors++; if (n !== 152) begin miscompares++; $display("FAIL good_latency: got %0d cycles expected 152", n); end
        vectors++; if ({done[0], pass[0], busy[0]} !== 3'b110) begin miscompares++; $display("FAIL good_status: got %b expected 110", {done[0], pass[0], busy[0]}); end
        vectors++; if (error_count[0] !== 16'd0) begin miscompares++; $display("FAIL good_err: got %0d expected 0", error_count[0]); end
        vectors++; if (g_fifo[0].n_wr !== 64) begin miscompares++; $display("FAIL good_nwr: got %0d expected 64", g_fifo[0].n_wr); end
        vectors++; if (g_fifo[0].n_bad !== 0) begin miscompares++; $display("FAIL good_wseq: got %0d bad writes expected 0", g_fifo[0].n_bad); end
        vectors++; if ({g_fifo[0].n_wff, g_fifo[0].n_ree} !== {32'd4, 32'd4}) begin miscompares++; $display("FAIL good_probes: got %0d/%0d expected 4/4", g_fifo[0].n_wff, g_fifo[0].n_ree); end
        vectors++; if (g_fifo[0].n_both !== 0) begin miscompares++; $display("FAIL good_overlap: got %0d expected 0", g_fifo[0].n_both); end
        repeat (5) @(posedge clk);
        #1;
        vectors++; if ({done[0], pass[0], wr_enb[0], rd_enb[0]} !== 4'b1100) begin miscompares++; $display("FAIL good_hold: got %b expected 1100", {done[0], pass[0], wr_enb[0], rd_enb[0]}); end
    endtask

    task automatic test_restart_from_done();
        int unsigned n;
        pulse_start(0);
        vectors++; if ({busy[0], done[0], pass[0]} !== 3'b100) begin miscompares++; $display("FAIL restart_status: got %b expected 100", {busy[0], done[0], pass[0]}); end
        wait_done(0, 2000, n);
        vectors++; if ({done[0], pass[0], n} !== {2'b11, 32'd152}) begin miscompares++; $display("FAIL restart_end: got done/pass %b cycles %0d expected 11 152", {done[0], pass[0]}, n); end
    endtask

    task automatic test_data_corrupt();
        int unsigned n;
        do_reset();
        corrupt_idx = 4;
        pulse_start(0);
        wait_done(0, 2000, n);
        vectors++; if (done[0] !== 1'b1) begin miscompares++; $display("FAIL corrupt_done: got %b expected 1 (waited %0d)", done[0], n); end
        vectors++; if (error_count[0] !== 16'd1) begin miscompares++; $display("FAIL corrupt_err: got %0d expected 1", error_count[0]); end
        vectors++; if (first_err_exp[0] !== 8'h04) begin miscompares++; $display("FAIL corrupt_first: got %h expected 04", first_err_exp[0]); end
        vectors++; if (pass[0] !== 1'b0) begin miscompares++; $display("FAIL corrupt_pass: got %b expected 0", pass[0]); end
        corrupt_idx = 32'hFFFF_FFFF;
    endtask

    task automatic test_no_full_flag();
        int unsigned n;
        do_reset();
        force_full0 = 1'b1;
        no_ovf      = 1'b1;
        pulse_start(0);
        wait_done(0, 2000, n);
        vectors++; if (done[0] !== 1'b1) begin miscompares++; $display("FAIL nofull_done: got %b expected 1 (waited %0d)", done[0], n); end
        vectors++; if (error_count[0] !== 16'd8) begin miscompares++; $display("FAIL nofull_err: got %0d expected 8", error_count[0]); end
        vectors++; if ({pass[0], first_err_exp[0]} !== 9'd0) begin miscompares++; $display("FAIL nofull_pass: got %b/%h expected 0/00", pass[0], first_err_exp[0]); end
        force_full0 = 1'b0;
        no_ovf      = 1'b0;
    endtask

    task automatic test_stall_timeout();
        do_reset();
        force_full1 = 1'b1;
        pulse_start(0);
        repeat (1023) @(posedge clk);
        #1;
        vectors++; if (done[0] !== 1'b0) begin miscompares++; $display("FAIL stall_early: got done %b expected 0", done[0]); end
        @(posedge clk);
        #1;
        vectors++; if ({done[0], busy[0], pass[0]} !== 3'b100) begin miscompares++; $display("FAIL stall_abort: got %b expected 100", {done[0], busy[0], pass[0]}); end
        vectors++; if (error_count[0] !== 16'd1) begin miscompares++; $display("FAIL stall_err: got %0d expected 1", error_count[0]); end
        vectors++; if ({g_fifo[0].n_wr, g_fifo[0].n_wff} !== 64'd0) begin miscompares++; $display("FAIL stall_writes: got %0d/%0d expected 0/0", g_fifo[0].n_wr, g_fifo[0].n_wff); end
        force_full1 = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        int unsigned n;
        do_reset();
        pulse_start(0);
        n = 0;
        while (rd_enb[0] !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        vectors++; if (rd_enb[0] !== 1'b1) begin miscompares++; $display("FAIL midrst_drain: got rd_enb %b expected 1", rd_enb[0]); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if ({busy[0], done[0], wr_enb[0], rd_enb[0]} !== 4'b0) begin miscompares++; $display("FAIL midrst_ctl: got %b expected 0000", {busy[0], done[0], wr_enb[0], rd_enb[0]}); end
        vectors++; if (error_count[0] !== 16'd0) begin miscompares++; $display("FAIL midrst_err: got %0d expected 0", error_count[0]); end
        rst = 1'b0;
        pulse_start(0);
        n = 0;
        while (g_fifo[0].n_wr == 0 && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        vectors++; if (g_fifo[0].first_wr !== 8'h00) begin miscompares++; $display("FAIL midrst_first_wr: got %h expected 00", g_fifo[0].first_wr); end
        wait_done(0, 2000, n);
        vectors++; if ({done[0], pass[0], error_count[0]} !== {2'b11, 16'd0}) begin miscompares++; $display("FAIL midrst_rerun: got %b err %0d expected 11 err 0", {done[0], pass[0]}, error_count[0]); end
    endtask

    task automatic test_wrap_and_start_ignored();
        int unsigned n;
        do_reset();
        pulse_start(1);
        repeat (50) @(posedge clk);
        #1;
        pulse_start(1);
        vectors++; if ({busy[1], done[1]} !== 2'b10) begin miscompares++; $display("FAIL wrap_busy: got %b expected 10", {busy[1], done[1]}); end
        wait_done(1, 3000, n);
        vectors++; if ({done[1], pass[1]} !== 2'b11) begin miscompares++; $display("FAIL wrap_status: got %b expected 11 (waited %0d)", {done[1], pass[1]}, n); end
        vectors++; if (error_count[1] !== 16'd0) begin miscompares++; $display("FAIL wrap_err: got %0d expected 0", error_count[1]); end
        vectors++; if ({g_fifo[1].n_wr, g_fifo[1].n_bad} !== {32'd320, 32'd0}) begin miscompares++; $display("FAIL wrap_writes: got %0d writes %0d bad expected 320 0", g_fifo[1].n_wr, g_fifo[1].n_bad); end
        vectors++; if (g_fifo[1].n_wff !== 20) begin miscompares++; $display("FAIL wrap_probes: got %0d expected 20", g_fifo[1].n_wff); end
    endtask

    initial begin
        test_reset();
        test_good_run();
        test_restart_from_done();
        test_data_corrupt();
        test_no_full_flag();
        test_stall_timeout();
        test_reset_mid_drain();
        test_wrap_and_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
